iir_coeff_loader: RTL and testbench

//  Coefficient writer for iir_filter_2nd_order: accepts 32-bit words from the GPIO/PS register path,

---
 rtl/iir_coeff_loader.sv | 157 +++++++++++++++
 tb/tb_iir_coeff_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coeff_loader.sv
// Double-buffered coefficient loader for the biquad: shadow writes, a stability check on commit,
// and an atomic shadow-to-active transfer on the next sample boundary.
module iir_coeff_loader #(
    parameter int                     COEFF_WIDTH = 32,
    parameter int                     LOG_A0      = 30,
    parameter logic [COEFF_WIDTH-1:0] RESET_GAIN  = 32'h10000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [2:0]             wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic                   sample_tick,
    input  logic [2:0]             rd_addr,
    output logic [COEFF_WIDTH-1:0] rd_data,
    output logic [COEFF_WIDTH-1:0] b0,
    output logic [COEFF_WIDTH-1:0] b1,
    output logic [COEFF_WIDTH-1:0] b2,
    output logic [COEFF_WIDTH-1:0] a1,
    output logic [COEFF_WIDTH-1:0] a2,
    output logic [COEFF_WIDTH-1:0] gain,
    output logic                   coeff_update,
    output logic                   pending,
    output logic                   err_unstable,
    output logic                   err_addr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        PENDING = 2'd2,
        APPLY   = 2'd3
    } state_t;

    localparam logic signed [COEFF_WIDTH-1:0] A2_LIMIT =
        {{(COEFF_WIDTH-1){1'b0}}, 1'b1} << LOG_A0;

    state_t                   state;
    state_t                   next_state;
    logic [COEFF_WIDTH-1:0]   shadow [0:5];
    logic [COEFF_WIDTH-1:0]   active [0:5];
    logic signed [COEFF_WIDTH-1:0] a2_shadow;
    logic                     a2_stable;
    logic                     wr_fire;
    logic                     shadow_we;
    logic                     addr_err_set;
    logic                     check_pass;
    logic                     check_fail;
    logic                     load_active;

    assign wr_fire   = wr_valid && wr_ready;
    assign a2_shadow = shadow[4];
    assign a2_stable = (a2_shadow < A2_LIMIT) && (a2_shadow > -A2_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        wr_ready     = 1'b0;
        pending      = 1'b0;
        shadow_we    = 1'b0;
        addr_err_set = 1'b0;
        check_pass   = 1'b0;
        check_fail   = 1'b0;
        load_active  = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    if (wr_addr <= 3'd5) begin
                        shadow_we = 1'b1;
                    end else if (wr_addr == 3'd6) begin
                        next_state = CHECK;
                    end else begin
                        addr_err_set = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (a2_stable) begin
                    check_pass = 1'b1;
                    next_state = PENDING;
                end else begin
                    check_fail = 1'b1;
                    next_state = IDLE;
                end
            end
            PENDING: begin
                pending = 1'b1;
                if (sample_tick) begin
                    next_state = APPLY;
                end
            end
            APPLY: begin
                load_active = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow/active banks, sticky error flags and the registered readback port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= (i == 5) ? RESET_GAIN : '0;
                active[i] <= (i == 5) ? RESET_GAIN : '0;
            end
            rd_data      <= '0;
            coeff_update <= 1'b0;
            err_unstable <= 1'b0;
            err_addr     <= 1'b0;
        end else begin
            coeff_update <= load_active;
            if (wr_fire && shadow_we) begin
                shadow[wr_addr] <= wr_data;
            end
            if (addr_err_set) begin
                err_addr <= 1'b1;
            end
            if (check_pass) begin
                err_unstable <= 1'b0;
                err_addr     <= 1'b0;
            end
            if (check_fail) begin
                err_unstable <= 1'b1;
            end
            if (load_active) begin
                for (int i = 0; i < 6; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (rd_addr <= 3'd5) begin
                rd_data <= shadow[rd_addr];
            end else if (rd_addr == 3'd6) begin
                rd_data <= {{(COEFF_WIDTH-5){1'b0}}, pending, err_unstable, err_addr, state};
            end else begin
                rd_data <= '0;
            end
        end
    end

    assign b0   = active[0];
    assign b1   = active[1];
    assign b2   = active[2];
    assign a1   = active[3];
    assign a2   = active[4];
    assign gain = active[5];

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: reset values, commit/apply timing, stability rejection,
// back-pressure while pending, reset during pending and the status readback word.
module tb_iir_coeff_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sample_tick;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] b0, b1, b2, a1, a2, gain;
    logic        coeff_update;
    logic        pending;
    logic        err_unstable;
    logic        err_addr;

    int checks      = 0;
    int errors      = 0;
    int pulse_count = 0;
    int pulse_mark;

    iir_coeff_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sample_tick  (sample_tick),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .b0           (b0),
        .b1           (b1),
        .b2           (b2),
        .a1           (a1),
        .a2           (a2),
        .gain         (gain),
        .coeff_update (coeff_update),
        .pending      (pending),
        .err_unstable (err_unstable),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (coeff_update) pulse_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Holds a write request until the loader accepts it; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) checkOutput("wr_accept_timeout", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    // Ticks once from PENDING and returns #1 after the edge that loads the active bank.
    task automatic tickAndApply();
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        sample_tick = 1'b0;
        rd_addr     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_b0", b0, 32'h0);
        checkOutput("rst_a1", a1, 32'h0);
        checkOutput("rst_a2", a2, 32'h0);
        checkOutput("rst_gain", gain, 32'h0001_0000);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_coeff_update", 32'(coeff_update), 32'd0);

        // Basic commit with delayed tick
        applyStimulus(3'd0, 32'h4000_0000);
        applyStimulus(3'd4, 32'h2000_0000);
        applyStimulus(3'd6, 32'h0);
        checkOutput("b0_hold_in_check", b0, 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("pending_set", 32'(pending), 32'd1);
        checkOutput("b0_hold_in_pending", b0, 32'h0);
        pulse_mark  = pulse_count;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        checkOutput("b0_hold_in_apply", b0, 32'h0);
        checkOutput("no_update_in_apply", 32'(coeff_update), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b0_applied", b0, 32'h4000_0000);
        checkOutput("a2_applied", a2, 32'h2000_0000);
        checkOutput("b1_unchanged", b1, 32'h0);
        checkOutput("gain_unchanged", gain, 32'h0001_0000);
        checkOutput("update_pulse", 32'(coeff_update), 32'd1);
        checkOutput("pending_cleared", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("update_pulse_end", 32'(coeff_update), 32'd0);
        checkOutput("one_pulse", 32'(pulse_count - pulse_mark), 32'd1);
        rd_addr = 3'd0;
        @(posedge clk);
        #1;
        checkOutput("rd_shadow_b0", rd_data, 32'h4000_0000);

        // Unstable a2 at both bounds, then a just-inside value
        applyStimulus(3'd4, 32'h4000_0000);
        applyStimulus(3'd6, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("err_unstable_pos", 32'(err_unstable), 32'd1);
        checkOutput("pending_after_reject", 32'(pending), 32'd0);
        rd_addr = 3'd6;
        @(posedge clk);
        #1;
        checkOutput("rd_status_unstable", rd_data, 32'h0000_0008);
        pulse_mark = pulse_count;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("no_pulse_after_reject", 32'(pulse_count - pulse_mark), 32'd0);
        checkOutput("a2_kept_after_reject", a2, 32'h2000_0000);
        applyStimulus(3'd4, 32'hC000_0000);
        applyStimulus(3'd6, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("err_unstable_neg", 32'(err_unstable), 32'd1);
        checkOutput("pending_after_neg_reject", 32'(pending), 32'd0);
        applyStimulus(3'd4, 32'hC000_0001);
        applyStimulus(3'd6, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("pending_neg_ok", 32'(pending), 32'd1);
        checkOutput("err_unstable_cleared", 32'(err_unstable), 32'd0);
        tickAndApply();
        checkOutput("a2_neg_applied", a2, 32'hC000_0001);
        checkOutput("update_neg", 32'(coeff_update), 32'd1);

        // Unchanged commit still applies; write during pending is back-pressured
        applyStimulus(3'd6, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("pending_reapply", 32'(pending), 32'd1);
        pulse_mark = pulse_count;
        @(negedge clk);
        wr_valid    = 1'b1;
        wr_addr     = 3'd0;
        wr_data     = 32'h1111_1111;
        sample_tick = 1'b1;
        checkOutput("ready_low_pending", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        checkOutput("ready_low_apply", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b0_reapplied", b0, 32'h4000_0000);
        checkOutput("update_reapply", 32'(coeff_update), 32'd1);
        checkOutput("ready_back", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_addr  = 3'd0;
        @(posedge clk);
        #1;
        checkOutput("rd_held_write", rd_data, 32'h1111_1111);
        checkOutput("b0_active_kept", b0, 32'h4000_0000);
        checkOutput("reapply_pulses", 32'(pulse_count - pulse_mark), 32'd1);

        // Reset in PENDING drops the commit
        applyStimulus(3'd6, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("pending_before_rst", 32'(pending), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("pending_after_rst", 32'(pending), 32'd0);
        pulse_mark = pulse_count;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("no_pulse_after_rst", 32'(pulse_count - pulse_mark), 32'd0);
        checkOutput("b0_rst_value", b0, 32'h0);
        checkOutput("a2_rst_value", a2, 32'h0);
        checkOutput("gain_rst_value", gain, 32'h0001_0000);
        checkOutput("rd_shadow_rst", rd_data, 32'h0);

        // Reserved address and status readback
        applyStimulus(3'd7, 32'hDEAD_BEEF);
        checkOutput("err_addr_set", 32'(err_addr), 32'd1);
        rd_addr = 3'd6;
        @(posedge clk);
        #1;
        checkOutput("rd_status_addr", rd_data, 32'h0000_0004);
        applyStimulus(3'd6, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("err_addr_cleared", 32'(err_addr), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rd_status_pending", rd_data, 32'h0000_0012);
        rd_addr = 3'd7;
        tickAndApply();
        checkOutput("update_final", 32'(coeff_update), 32'd1);
        checkOutput("rd_reserved", rd_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
